// File: rtl/serializer_scheduler_if.sv
// Bus between the word producers and the serializer scheduler.
// The scheduler uses the slave view; the producer/observer side uses master.
interface serializer_scheduler_if #(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_REQ    = 4
);
    localparam int SRC_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            req_ready;
    logic                          dout;
    logic                          dout_valid;
    logic                          dout_first;
    logic [SRC_W-1:0]              dout_src;
    logic                          busy;

    modport master (
        output req_valid, req_data,
        input  req_ready, dout, dout_valid, dout_first, dout_src, busy
    );

    modport slave (
        input  req_valid, req_data,
        output req_ready, dout, dout_valid, dout_first, dout_src, busy
    );
endinterface

// File: rtl/serializer_scheduler.sv
// Round-robin scheduler feeding one LSB-first shift register from NUM_REQ
// word requesters, with GAP_CYCLES idle cycles between frames.
module serializer_scheduler #(
    parameter  int DATA_WIDTH = 16,
    parameter  int NUM_REQ    = 4,
    parameter  int GAP_CYCLES = 1,
    localparam int SRC_W      = $clog2(NUM_REQ)
) (
    input  logic                    clk,
    input  logic                    resetn,
    serializer_scheduler_if.slave   bus
);
    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_GAP} state_t;

    localparam int CNT_W = $clog2(DATA_WIDTH);
    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam bit HAS_GAP = (GAP_CYCLES > 0);

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [GAP_W-1:0]      gap_q, gap_d;
    logic [SRC_W-1:0]      ptr_q, ptr_d;
    logic [SRC_W-1:0]      src_q, src_d;

    logic                  accept_slot;
    logic                  found;
    logic                  handshake;
    logic [SRC_W-1:0]      grant_idx;
    logic [2*NUM_REQ-1:0]  valid_dbl;
    logic [NUM_REQ-1:0]    valid_rot;

    // Decide whether this cycle is allowed to accept a new word.
    always_comb begin
        accept_slot = 1'b0;
        case (state_q)
            S_IDLE:  accept_slot = 1'b1;
            S_SHIFT: accept_slot = !HAS_GAP && (cnt_q == CNT_LAST);
            S_GAP:   accept_slot = HAS_GAP && (gap_q == GAP_LAST);
            default: accept_slot = 1'b0;
        endcase
    end

    // Rotate valids so bit k is requester (ptr+k) mod NUM_REQ.
    assign valid_dbl = {bus.req_valid, bus.req_valid} >> ptr_q;
    assign valid_rot = valid_dbl[NUM_REQ-1:0];

    // First valid requester at or after the pointer, wrapping around.
    always_comb begin
        logic [SRC_W:0] sum;
        found     = 1'b0;
        grant_idx = '0;
        sum       = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (valid_rot[k]) begin
                found = 1'b1;
                sum   = {1'b0, ptr_q} + (SRC_W+1)'(k);
                if (int'(sum) >= NUM_REQ) begin
                    sum = sum - (SRC_W+1)'(NUM_REQ);
                end
                grant_idx = sum[SRC_W-1:0];
            end
        end
    end

    assign handshake = accept_slot && found;

    // One-hot ready; forced low while reset is asserted.
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_ready
            assign bus.req_ready[gi] = resetn && handshake && (grant_idx == SRC_W'(gi));
        end
    endgenerate

    // Next-state logic: shifting, gap counting and loading a granted word.
    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        gap_d   = gap_q;
        ptr_d   = ptr_q;
        src_d   = src_q;
        case (state_q)
            S_IDLE: ;
            S_SHIFT: begin
                shreg_d = shreg_q >> 1;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    if (HAS_GAP) begin
                        state_d = S_GAP;
                        gap_d   = '0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_GAP: begin
                gap_d = gap_q + 1'b1;
                if (gap_q == GAP_LAST) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // A handshake in any accept slot starts a new frame next cycle.
        if (handshake) begin
            state_d = S_SHIFT;
            shreg_d = bus.req_data[int'(grant_idx)*DATA_WIDTH +: DATA_WIDTH];
            cnt_d   = '0;
            src_d   = grant_idx;
            ptr_d   = (int'(grant_idx) == NUM_REQ - 1) ? '0 : grant_idx + 1'b1;
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
            gap_q   <= '0;
            ptr_q   <= '0;
            src_q   <= '0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            gap_q   <= gap_d;
            ptr_q   <= ptr_d;
            src_q   <= src_d;
        end
    end

    assign bus.dout       = (state_q == S_SHIFT) && shreg_q[0];
    assign bus.dout_valid = (state_q == S_SHIFT);
    assign bus.dout_first = (state_q == S_SHIFT) && (cnt_q == '0);
    assign bus.dout_src   = src_q;
    assign bus.busy       = (state_q != S_IDLE);
endmodule

// File: tb/tb_serializer_scheduler.sv
// Directed bench: one scheduler with a 1-cycle gap (u_g1) and one
// back-to-back instance (u_g0), sharing clock and reset.
module tb_serializer_scheduler;
    localparam int DW = 16;
    localparam int NR = 4;

    logic clk;
    logic resetn;
    int   checks;
    int   errors;

    serializer_scheduler_if #(.DATA_WIDTH(DW), .NUM_REQ(NR)) if1 ();
    serializer_scheduler_if #(.DATA_WIDTH(DW), .NUM_REQ(NR)) if0 ();

    serializer_scheduler #(.DATA_WIDTH(DW), .NUM_REQ(NR), .GAP_CYCLES(1)) u_g1 (
        .clk    (clk),
        .resetn (resetn),
        .bus    (if1.slave)
    );

    serializer_scheduler #(.DATA_WIDTH(DW), .NUM_REQ(NR), .GAP_CYCLES(0)) u_g0 (
        .clk    (clk),
        .resetn (resetn),
        .bus    (if0.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    // Check one frame starting at the current (bit 0) cycle.
    task automatic run_frame(input bit sel, input int src, input logic [15:0] word,
                             input logic [3:0] rdy_last, input logic [3:0] drop,
                             input logic [3:0] pulse, input int stop_at);
        for (int b = 0; b < DW; b++) begin
            if (b > 0) cyc();
            chk($sformatf("dout b%0d", b),  sel ? if0.dout       : if1.dout,       word[b]);
            chk($sformatf("valid b%0d", b), sel ? if0.dout_valid : if1.dout_valid, 1);
            chk($sformatf("first b%0d", b), sel ? if0.dout_first : if1.dout_first, (b == 0));
            chk($sformatf("src b%0d", b),   sel ? if0.dout_src   : if1.dout_src,   src);
            if (b == DW - 1)
                chk("ready last bit", sel ? if0.req_ready : if1.req_ready, rdy_last);
            if (b == 0) begin
                if (sel) if0.req_valid = if0.req_valid & ~drop;
                else     if1.req_valid = if1.req_valid & ~drop;
            end
            if (b == 4)  if1.req_valid = if1.req_valid | pulse;
            if (b == 10) if1.req_valid = if1.req_valid & ~pulse;
            if (b == stop_at) break;
        end
        $display("frame dut=g%0d src=%0d word=%h", sel ? 0 : 1, src, word);
    endtask

    // After the last bit of a g1 frame: one gap cycle then idle.
    task automatic gap_then_idle(input logic [3:0] gap_ready);
        cyc();
        chk("gap valid", if1.dout_valid, 0);
        chk("gap dout",  if1.dout, 0);
        chk("gap busy",  if1.busy, 1);
        chk("gap ready", if1.req_ready, gap_ready);
        if (gap_ready == 4'b0000) begin
            cyc();
            chk("idle busy",  if1.busy, 0);
            chk("idle valid", if1.dout_valid, 0);
        end
    endtask

    logic [15:0] cw [0:3];
    int          order [0:4];

    initial begin
        checks = 0;
        errors = 0;
        resetn = 1'b1;
        if1.req_valid = '0; if1.req_data = '0;
        if0.req_valid = '0; if0.req_data = '0;
        cw[0] = 16'h8001; cw[1] = 16'h4002; cw[2] = 16'h2004; cw[3] = 16'h1008;
        order[0] = 0; order[1] = 1; order[2] = 2; order[3] = 3; order[4] = 0;
        #2 resetn = 1'b0;

        // Reset state, ready held low even with valids present.
        cyc();
        chk("rst dout",  if1.dout, 0);
        chk("rst valid", if1.dout_valid, 0);
        chk("rst first", if1.dout_first, 0);
        chk("rst src",   if1.dout_src, 0);
        chk("rst busy",  if1.busy, 0);
        if1.req_valid = 4'hF;
        #1 chk("rst ready", if1.req_ready, 0);
        if1.req_valid = 4'h0;
        cyc();
        resetn = 1'b1;
        #1 chk("idle ready none", if1.req_ready, 0);

        // Single requester 2, word A5C3.
        if1.req_data[2*DW +: DW] = 16'hA5C3;
        if1.req_valid = 4'b0100;
        #1 chk("single ready", if1.req_ready, 4'b0100);
        cyc();
        run_frame(0, 2, 16'hA5C3, 4'b0000, 4'b0100, 4'b0000, DW - 1);
        gap_then_idle(4'b0000);
        chk("src held", if1.dout_src, 2);

        // Grant requester 1 alone (pointer 3 wraps to 1), leaving pointer 2.
        if1.req_data[1*DW +: DW] = 16'h0F0F;
        if1.req_valid = 4'b0010;
        #1 chk("wrap ready", if1.req_ready, 4'b0010);
        cyc();
        run_frame(0, 1, 16'h0F0F, 4'b0000, 4'b0010, 4'b0000, DW - 1);
        gap_then_idle(4'b0000);

        // Pointer fairness: 0 and 3 valid with pointer 2 -> 3 then 0.
        if1.req_data[0*DW +: DW] = 16'hC0DE;
        if1.req_data[3*DW +: DW] = 16'h7E57;
        if1.req_valid = 4'b1001;
        #1 chk("fair ready 3", if1.req_ready, 4'b1000);
        cyc();
        run_frame(0, 3, 16'h7E57, 4'b0000, 4'b1000, 4'b0000, DW - 1);
        gap_then_idle(4'b0001);
        cyc();
        // Requester 1 raises valid mid-frame and withdraws before the slot.
        if1.req_data[1*DW +: DW] = 16'h3CF1;
        run_frame(0, 0, 16'hC0DE, 4'b0000, 4'b0001, 4'b0010, DW - 1);
        gap_then_idle(4'b0000);

        // Pointer stayed at 1: with 0 and 1 valid, 1 wins.
        if1.req_valid = 4'b0011;
        #1 chk("withdraw ptr", if1.req_ready, 4'b0010);
        cyc();
        run_frame(0, 1, 16'h3CF1, 4'b0000, 4'b0000, 4'b0000, 7);

        // Reset at bit 7 (bit 7 of 3CF1 is 1).
        if1.req_valid = 4'b0010;
        resetn = 1'b0;
        #1;
        chk("midrst dout",  if1.dout, 0);
        chk("midrst valid", if1.dout_valid, 0);
        chk("midrst busy",  if1.busy, 0);
        chk("midrst ready", if1.req_ready, 0);
        cyc();
        resetn = 1'b1;
        #1 chk("post rst ready", if1.req_ready, 4'b0010);
        cyc();
        run_frame(0, 1, 16'h3CF1, 4'b0000, 4'b0010, 4'b0000, DW - 1);
        gap_then_idle(4'b0000);

        // Full contention after a fresh reset: grants 0,1,2,3,0.
        resetn = 1'b0;
        cyc();
        resetn = 1'b1;
        for (int i = 0; i < NR; i++) if1.req_data[i*DW +: DW] = cw[i];
        if1.req_valid = 4'hF;
        #1 chk("cont ready 0", if1.req_ready, 4'b0001);
        for (int f = 0; f < 5; f++) begin
            cyc();
            run_frame(0, order[f], cw[order[f]], 4'b0000,
                      (f == 4) ? 4'hF : 4'h0, 4'b0000, DW - 1);
            if (f < 4) gap_then_idle(4'b0001 << order[f + 1]);
            else       gap_then_idle(4'b0000);
        end

        // Back-to-back on the zero-gap instance.
        if0.req_data[0*DW +: DW] = 16'h1234;
        if0.req_data[1*DW +: DW] = 16'hBEEF;
        if0.req_valid = 4'b0011;
        #1 chk("b2b ready 0", if0.req_ready, 4'b0001);
        cyc();
        run_frame(1, 0, 16'h1234, 4'b0010, 4'b0001, 4'b0000, DW - 1);
        cyc();
        run_frame(1, 1, 16'hBEEF, 4'b0000, 4'b0010, 4'b0000, DW - 1);
        cyc();
        chk("b2b end valid", if0.dout_valid, 0);
        chk("b2b end busy",  if0.busy, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/serializer_scheduler.md
Name: serializer_scheduler

Overview:
- Round-robin scheduler that shares one LSB-first parallel-to-serial shift register among NUM_REQ parallel-word requesters.
- Grants one requester per frame, loads its word, and shifts out DATA_WIDTH bits.
- Inserts GAP_CYCLES idle bits between frames and reports frame start and source ID alongside the serial stream.
- Sits between multiple word producers and a single serial output lane.

Parameters:
- DATA_WIDTH, 16, width of each request word and frame length in bits (>=2).
- NUM_REQ, 4, number of requesters (>=2).
- GAP_CYCLES, 1, idle cycles forced between frames (0 allowed = back-to-back).
- SRC_W, $clog2(NUM_REQ), width of dout_src (derived, not overridden).

Ports:
- clk  in  1  rising-edge clock
- resetn  in  1  asynchronous active-low reset
- req_valid  in  NUM_REQ  per-requester word valid
- req_data  in  NUM_REQ*DATA_WIDTH  requester i word at bits [i*DATA_WIDTH +: DATA_WIDTH]
- req_ready  out  NUM_REQ  one-hot grant/accept; handshake when req_valid[i]&req_ready[i]
- dout  out  1  serial data, LSB first; 0 when dout_valid=0
- dout_valid  out  1  high on every frame bit
- dout_first  out  1  high on bit 0 of each frame only
- dout_src  out  SRC_W  index of requester owning current frame; held after frame
- busy  out  1  high in SHIFT or GAP

Behaviour:
- Reset (async assert, sync deassert use):
  - state=IDLE, shift reg=0, bit count=0, gap count=0, rr pointer=0.
  - All outputs 0; req_ready=0 during reset.
- States: IDLE, SHIFT, GAP.
- Accept slot: cycle in which req_ready may assert. Occurs:
  - in IDLE;
  - in the last SHIFT cycle (bit DATA_WIDTH-1) when GAP_CYCLES=0;
  - in the last GAP cycle when GAP_CYCLES>0.
- Arbitration in an accept slot: combinational search from rr pointer upward, modulo NUM_REQ; first i with req_valid[i] set gets req_ready[i]=1, all others 0. No valid -> req_ready all 0.
- Handshake (any accept slot):
  - Next cycle: state=SHIFT, shift reg<=word, count=0, dout_src<=i, rr pointer<=(i+1) mod NUM_REQ.
- SHIFT, per cycle:
  - dout=shreg[0], dout_valid=1, dout_first=(count==0).
  - Shift reg >> 1 with zero fill; count++.
  - At count==DATA_WIDTH-1:
    - GAP_CYCLES>0 -> GAP (gap count=0);
    - else handshake -> SHIFT with new word, no bubble;
    - else -> IDLE.
- GAP:
  - dout=0, dout_valid=0, dout_first=0 for exactly GAP_CYCLES cycles.
  - On the last gap cycle: handshake -> SHIFT next cycle; else -> IDLE.
- Frame latency: handshake in cycle T -> bit 0 on dout in T+1, bit DATA_WIDTH-1 in T+DATA_WIDTH.
- Protocol: a requester holds req_valid and req_data stable until ready. Dropping valid before grant is legal and simply forfeits arbitration. Data is sampled only at handshake.
- rr pointer advances only on handshake; an unserved requester keeps its position.
- Reset mid-frame aborts immediately: outputs 0 in the same cycle resetn falls; no partial resume.
- Simultaneous valid from all requesters: served in order ptr, ptr+1, ...; each gets exactly one frame before any repeat.

Test Plan:
- Single requester: NUM_REQ=4, req 2 valid with 16'hA5C3 in IDLE. Required response:
  - req_ready=4'b0100 that cycle.
  - Next 16 cycles: dout=1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1.
  - dout_first only on the first of those cycles; dout_src=2.
  - Then one gap cycle, then IDLE with busy=0.
- Full contention: all 4 valid continuously, distinct words. Required response:
  - Grants in order 0,1,2,3,0.
  - Each frame 16 bits followed by exactly 1 idle cycle.
  - dout_src matches each grant.
- Back-to-back: GAP_CYCLES=0, req 0 and req 1 valid. Required response:
  - Bit 15 of frame 0 is followed immediately by frame 1 bit 0 with dout_first=1.
  - No dout_valid bubble between frames.
- Pointer fairness: pointer=2 (after granting 1), req 0 and req 3 valid. Required response:
  - req 3 granted first, then req 0.
- Reset mid-frame: resetn low at bit 7. Required response:
  - dout, dout_valid, busy, req_ready go to 0 immediately.
  - After release, pointer=0 and a new req 1 frame starts cleanly from bit 0.
- Withdrawn request: req 1 valid during SHIFT, dropped before the accept slot. Required response:
  - No grant issued; scheduler returns to IDLE.
  - rr pointer unchanged.
